// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the trigger-board command protocol: opcodes, FSM states,
// capacities and the opcode -> (argument count, response count) table.
package serial_cmd_pkg;

    localparam int MAX_ARGS = 10;
    localparam int MAX_RESP = 64;

    localparam logic [7:0] CMD_VERSION        = 8'd0;
    localparam logic [7:0] CMD_SET_MODE       = 8'd1;
    localparam logic [7:0] CMD_SET_CHANNEL    = 8'd2;
    localparam logic [7:0] CMD_READ_REG       = 8'd3;
    localparam logic [7:0] CMD_ARM            = 8'd4;
    localparam logic [7:0] CMD_DISARM         = 8'd5;
    localparam logic [7:0] CMD_SET_THRESH     = 8'd6;
    localparam logic [7:0] CMD_SET_WINDOW     = 8'd7;
    localparam logic [7:0] CMD_GET_STATUS     = 8'd8;
    localparam logic [7:0] CMD_RESET_COUNTERS = 8'd9;
    localparam logic [7:0] CMD_READ_COUNTERS  = 8'd10;
    localparam logic [7:0] CMD_SET_PRESCALE   = 8'd11;
    localparam logic [7:0] CMD_SOFT_TRIG      = 8'd12;
    localparam logic [7:0] CMD_CLEAR_FIFO     = 8'd13;
    localparam logic [7:0] CMD_SET_MASK       = 8'd14;
    localparam logic [7:0] CMD_SET_DELAY      = 8'd15;
    localparam logic [7:0] CMD_READ_FIFO      = 8'd16;
    localparam logic [7:0] CMD_GET_TEMP       = 8'd17;
    localparam logic [7:0] CMD_SYNC_START     = 8'd18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_WAIT = 3'd1,
        ST_TX_GAP  = 3'd2,
        ST_RECV    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Returns {nargs[3:0], nresp[6:0]}; unknown opcodes carry no args and expect no reply.
    function automatic logic [10:0] cmd_lengths(input logic [7:0] opcode);
        logic [10:0] len;
        case (opcode)
            CMD_VERSION:        len = {4'd0, 7'd1};
            CMD_SET_MODE:       len = {4'd1, 7'd0};
            CMD_SET_CHANNEL:    len = {4'd1, 7'd0};
            CMD_READ_REG:       len = {4'd1, 7'd1};
            CMD_ARM:            len = {4'd0, 7'd0};
            CMD_DISARM:         len = {4'd0, 7'd0};
            CMD_SET_THRESH:     len = {4'd4, 7'd0};
            CMD_SET_WINDOW:     len = {4'd4, 7'd0};
            CMD_GET_STATUS:     len = {4'd0, 7'd1};
            CMD_RESET_COUNTERS: len = {4'd0, 7'd0};
            CMD_READ_COUNTERS:  len = {4'd0, 7'd32};
            CMD_SET_PRESCALE:   len = {4'd1, 7'd0};
            CMD_SOFT_TRIG:      len = {4'd0, 7'd0};
            CMD_CLEAR_FIFO:     len = {4'd0, 7'd0};
            CMD_SET_MASK:       len = {4'd8, 7'd0};
            CMD_SET_DELAY:      len = {4'd1, 7'd0};
            CMD_READ_FIFO:      len = {4'd0, 7'd64};
            CMD_GET_TEMP:       len = {4'd0, 7'd1};
            CMD_SYNC_START:     len = {4'd0, 7'd7};
            default:            len = {4'd0, 7'd0};
        endcase
        return len;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte silence timer: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYCLES-1, holding there until cleared.
module cmd_timeout_timer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    assign expired_o = (cnt_q == (TIMEOUT_CYCLES - 24'd1));

    // Next count: clear wins over counting; saturate at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 24'd0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 24'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_cmd_initiator.sv
// Host-side command initiator: sends opcode plus argument bytes to the UART tx core,
// then gathers the opcode-determined number of response bytes with an inter-byte timeout.
module serial_cmd_initiator
    import serial_cmd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_opcode,
    input  logic [8*MAX_ARGS-1:0] cmd_args,
    input  logic                  txBusy,
    output logic                  txStart,
    output logic [7:0]            txData,
    input  logic                  rxReady,
    input  logic [7:0]            rxData,
    output logic                  resp_valid,
    output logic [7:0]            resp_data,
    output logic [5:0]            resp_index,
    output logic                  done,
    output logic                  timed_out,
    output logic [6:0]            resp_count,
    output logic [7:0]            rx_discards
);

    state_e                state_q;
    logic [7:0]            opcode_q;
    logic [8*MAX_ARGS-1:0] args_q;
    logic [3:0]            nargs_q;
    logic [6:0]            nresp_q;
    logic [6:0]            cnt_q;
    logic                  cmd_ready_q;
    logic                  tx_start_q;
    logic [7:0]            tx_data_q;
    logic                  resp_valid_q;
    logic [7:0]            resp_data_q;
    logic [5:0]            resp_index_q;
    logic                  done_q;
    logic                  timed_out_q;
    logic [6:0]            resp_count_q;
    logic [7:0]            rx_discards_q;

    logic [10:0]           lengths_s;
    logic [6:0]            cnt_inc_s;
    logic                  timer_clear_s;
    logic                  timer_enable_s;
    logic                  timer_expired_s;

    assign lengths_s      = cmd_lengths(cmd_opcode);
    assign cnt_inc_s      = cnt_q + 7'd1;
    // The timer restarts on every received byte and whenever we are not listening.
    assign timer_clear_s  = (state_q != ST_RECV) || rxReady;
    assign timer_enable_s = (state_q == ST_RECV);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (timer_clear_s),
        .enable_i (timer_enable_s),
        .expired_o(timer_expired_s)
    );

    // Command FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            opcode_q      <= 8'd0;
            args_q        <= '0;
            nargs_q       <= 4'd0;
            nresp_q       <= 7'd0;
            cnt_q         <= 7'd0;
            cmd_ready_q   <= 1'b1;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'd0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= 8'd0;
            resp_index_q  <= 6'd0;
            done_q        <= 1'b0;
            timed_out_q   <= 1'b0;
            resp_count_q  <= 7'd0;
            rx_discards_q <= 8'd0;
        end else begin
            tx_start_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            done_q       <= 1'b0;

            if (rxReady && (state_q != ST_RECV) && (rx_discards_q != 8'hFF)) begin
                rx_discards_q <= rx_discards_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        opcode_q    <= cmd_opcode;
                        args_q      <= cmd_args;
                        nargs_q     <= lengths_s[10:7];
                        nresp_q     <= lengths_s[6:0];
                        cnt_q       <= 7'd0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (!txBusy) begin
                        tx_data_q  <= (cnt_q == 7'd0) ? opcode_q : args_q[7:0];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_TX_GAP;
                    end
                end
                ST_TX_GAP: begin
                    // Arguments go out from the low byte, so shift after each one is sent.
                    if (cnt_q != 7'd0) begin
                        args_q <= {8'd0, args_q[8*MAX_ARGS-1:8]};
                    end
                    if (cnt_q == {3'd0, nargs_q}) begin
                        cnt_q <= 7'd0;
                        if (nresp_q != 7'd0) begin
                            state_q <= ST_RECV;
                        end else begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            timed_out_q  <= 1'b0;
                            resp_count_q <= 7'd0;
                        end
                    end else begin
                        cnt_q   <= cnt_inc_s;
                        state_q <= ST_TX_WAIT;
                    end
                end
                ST_RECV: begin
                    if (rxReady) begin
                        resp_data_q  <= rxData;
                        resp_index_q <= cnt_q[5:0];
                        resp_valid_q <= 1'b1;
                        cnt_q        <= cnt_inc_s;
                        if (cnt_inc_s == nresp_q) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            timed_out_q  <= 1'b0;
                            resp_count_q <= cnt_inc_s;
                        end
                    end else if (timer_expired_s) begin
                        state_q      <= ST_DONE;
                        done_q       <= 1'b1;
                        timed_out_q  <= 1'b1;
                        resp_count_q <= cnt_q;
                    end
                end
                ST_DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign txStart     = tx_start_q;
    assign txData      = tx_data_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_index  = resp_index_q;
    assign done        = done_q;
    assign timed_out   = timed_out_q;
    assign resp_count  = resp_count_q;
    assign rx_discards = rx_discards_q;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Directed bench for serial_cmd_initiator: a tx core model that stays busy after each
// byte, hand-driven response bytes, and inline checks per scenario.
module tb_serial_cmd_initiator;
    import serial_cmd_pkg::*;

    localparam int BUSY_LEN = 3;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [79:0] cmd_args;
    logic        txBusy;
    logic        txStart;
    logic [7:0]  txData;
    logic        rxReady;
    logic [7:0]  rxData;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [5:0]  resp_index;
    logic        done;
    logic        timed_out;
    logic [6:0]  resp_count;
    logic [7:0]  rx_discards;

    int          checks;
    int          failures;
    int          cyc;
    int          busy_left;
    int          busy_viol;
    int          done_cnt;
    int          done_cyc;
    logic        done_to;
    logic [6:0]  done_rc;
    int          last_tx_cyc;
    logic [7:0]  tx_log[$];
    logic [7:0]  rdata_log[$];
    logic [5:0]  ridx_log[$];

    serial_cmd_initiator #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_args(cmd_args), .txBusy(txBusy), .txStart(txStart),
        .txData(txData), .rxReady(rxReady), .rxData(rxData), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_index(resp_index), .done(done), .timed_out(timed_out),
        .resp_count(resp_count), .rx_discards(rx_discards)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge, log DUT events, update the tx-busy model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (txStart) begin
            if (txBusy) busy_viol++;
            tx_log.push_back(txData);
            last_tx_cyc = cyc;
            busy_left = BUSY_LEN;
        end
        if (resp_valid) begin
            rdata_log.push_back(resp_data);
            ridx_log.push_back(resp_index);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_to = timed_out;
            done_rc = resp_count;
        end
        txBusy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        rdata_log.delete();
        ridx_log.delete();
        done_cnt = 0;
        busy_viol = 0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [79:0] args);
        cmd_opcode = op;
        cmd_args = args;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int b;
        b = 0;
        while (tx_log.size() < n && b < 400) begin
            tick();
            b++;
        end
        ok = (tx_log.size() >= n);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rxData = d;
        rxReady = 1'b1;
        tick();
        rxReady = 1'b0;
    endtask

    task automatic test_reset();
        logic [41:0] obs;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        obs = {cmd_ready, txStart, txData, resp_valid, resp_data, resp_index,
               done, timed_out, resp_count, rx_discards};
        checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 7'd0, 8'h00}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", obs,
                     {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 7'd0, 8'h00});
        end
    endtask

    task automatic test_version();
        bit ok;
        int rx_cyc;
        clear_logs();
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ver_ready got=%b exp=1", cmd_ready); end
        send_cmd(CMD_VERSION, 80'd0);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ver_tx_wait got=%0d bytes exp=1", tx_log.size()); end
        tick();
        rx_byte(8'h08);
        rx_cyc = cyc;
        tick();
        tick();
        checks++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h00) begin
            failures++; $display("FAIL ver_tx got=%0d bytes exp=1 byte 00", tx_log.size());
        end
        checks++;
        if (rdata_log.size() != 1 || rdata_log[0] !== 8'h08 || ridx_log[0] !== 6'd0) begin
            failures++; $display("FAIL ver_resp got=%0d strobes exp=1 (data 08 idx 0)", rdata_log.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != rx_cyc) begin
            failures++; $display("FAIL ver_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc, rx_cyc);
        end
        checks++;
        if (done_rc !== 7'd1 || done_to !== 1'b0) begin
            failures++; $display("FAIL ver_status got=rc%0d to%b exp=rc1 to0", done_rc, done_to);
        end
    endtask

    task automatic test_args();
        bit ok;
        logic [7:0] exp_b [5] = '{8'h07, 8'h78, 8'h56, 8'h34, 8'h12};
        clear_logs();
        tick();
        send_cmd(CMD_SET_WINDOW, 80'h12345678);
        // A second request held during the transfer must be ignored.
        cmd_valid = 1'b1;
        cmd_opcode = 8'h09;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL args_busy_ready got=%b exp=0", cmd_ready); end
        wait_tx(5, ok);
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL args_tx_wait got=%0d bytes exp=5", tx_log.size()); end
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= tx_log.size() || tx_log[i] !== exp_b[i]) begin
                failures++; $display("FAIL args_byte%0d got=%h exp=%h", i,
                                     (i < tx_log.size()) ? tx_log[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++;
        if (tx_log.size() != 5 || busy_viol != 0) begin
            failures++; $display("FAIL args_tx_count got=%0d viol=%0d exp=5 viol=0", tx_log.size(), busy_viol);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_tx_cyc + 1 || done_rc !== 7'd0 || done_to !== 1'b0) begin
            failures++; $display("FAIL args_done got=%0d@%0d rc%0d exp=1@%0d rc0",
                                 done_cnt, done_cyc, done_rc, last_tx_cyc + 1);
        end
    endtask

    task automatic test_long_resp();
        bit ok;
        int bad;
        clear_logs();
        tick();
        send_cmd(CMD_READ_FIFO, 80'd0);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL fifo_tx_wait got=%0d bytes exp=1", tx_log.size()); end
        tick();
        for (int i = 0; i < 64; i++) begin
            rx_byte(8'(i));
            tick();
        end
        tick();
        checks++;
        if (rdata_log.size() != 64) begin
            failures++; $display("FAIL fifo_strobes got=%0d exp=64", rdata_log.size());
        end
        bad = 0;
        for (int i = 0; i < rdata_log.size(); i++) begin
            if (rdata_log[i] !== 8'(i) || ridx_log[i] !== 6'(i)) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL fifo_data got=%0d bad bytes exp=0", bad); end
        checks++;
        if (done_cnt != 1 || done_rc !== 7'd64 || done_to !== 1'b0) begin
            failures++; $display("FAIL fifo_done got=%0d rc%0d to%b exp=1 rc64 to0", done_cnt, done_rc, done_to);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int last_rx;
        int b;
        clear_logs();
        tick();
        send_cmd(CMD_SYNC_START, 80'd0);
        wait_tx(1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL to_tx_wait got=%0d bytes exp=1", tx_log.size()); end
        tick();
        last_rx = 0;
        for (int i = 0; i < 3; i++) begin
            rx_byte(8'hA1 + 8'(i));
            last_rx = cyc;
            tick();
        end
        b = 0;
        while (done_cnt == 0 && b < 300) begin
            tick();
            b++;
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_rx + 100) begin
            failures++; $display("FAIL to_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc, last_rx + 100);
        end
        checks++;
        if (done_to !== 1'b1 || done_rc !== 7'd3) begin
            failures++; $display("FAIL to_status got=to%b rc%0d exp=to1 rc3", done_to, done_rc);
        end
        checks++;
        if (rdata_log.size() != 3 || rdata_log[2] !== 8'hA3 || ridx_log[2] !== 6'd2) begin
            failures++; $display("FAIL to_resp got=%0d strobes exp=3 (last A3 idx 2)", rdata_log.size());
        end
    endtask

    task automatic test_discards();
        clear_logs();
        tick();
        checks++;
        if (rx_discards !== 8'd0) begin failures++; $display("FAIL disc_start got=%0d exp=0", rx_discards); end
        for (int i = 0; i < 3; i++) begin
            rx_byte(8'h55);
            tick();
        end
        checks++;
        if (rx_discards !== 8'd3) begin failures++; $display("FAIL disc_three got=%0d exp=3", rx_discards); end
        rxData = 8'hAA;
        rxReady = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        rxReady = 1'b0;
        tick();
        checks++;
        if (rx_discards !== 8'd255) begin failures++; $display("FAIL disc_sat got=%0d exp=255", rx_discards); end
        checks++;
        if (rdata_log.size() != 0 || done_cnt != 0) begin
            failures++; $display("FAIL disc_quiet got=%0d strobes %0d done exp=0 0", rdata_log.size(), done_cnt);
        end
    endtask

    task automatic test_midreset();
        bit ok;
        logic [41:0] obs;
        clear_logs();
        tick();
        send_cmd(CMD_SET_MASK, 80'h8877665544332211);
        wait_tx(4, ok);
        checks++;
        if (!ok || tx_log[3] !== 8'h33) begin
            failures++; $display("FAIL mid_tx got=%0d bytes exp=4 (last 33)", tx_log.size());
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {cmd_ready, txStart, txData, resp_valid, resp_data, resp_index,
               done, timed_out, resp_count, rx_discards};
        checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 7'd0, 8'h00}) begin
            failures++; $display("FAIL mid_reset_values got=%h exp=%h", obs,
                                 {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 7'd0, 8'h00});
        end
        tick();
        tick();
        rst_n = 1'b1;
        busy_left = 0;
        txBusy = 1'b0;
        clear_logs();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (done_cnt != 0 || tx_log.size() != 0) begin
            failures++; $display("FAIL mid_silent got=%0d done %0d tx exp=0 0", done_cnt, tx_log.size());
        end
        send_cmd(CMD_READ_REG, 80'h55);
        wait_tx(2, ok);
        tick();
        rx_byte(8'h99);
        tick();
        checks++;
        if (!ok || tx_log[0] !== 8'h03 || tx_log[1] !== 8'h55) begin
            failures++; $display("FAIL mid_next_tx got=%0d bytes exp=2 (03 55)", tx_log.size());
        end
        checks++;
        if (done_cnt != 1 || done_rc !== 7'd1 || rdata_log.size() != 1 || rdata_log[0] !== 8'h99) begin
            failures++; $display("FAIL mid_next_done got=%0d rc%0d exp=1 rc1 data 99", done_cnt, done_rc);
        end
    endtask

    task automatic test_unknown();
        bit ok;
        clear_logs();
        tick();
        send_cmd(8'hC8, 80'hFF);
        wait_tx(1, ok);
        tick();
        tick();
        checks++;
        if (!ok || tx_log.size() != 1 || tx_log[0] !== 8'hC8) begin
            failures++; $display("FAIL unk_tx got=%0d bytes exp=1 (C8)", tx_log.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_tx_cyc + 1 || done_rc !== 7'd0) begin
            failures++; $display("FAIL unk_done got=%0d@%0d exp=1@%0d", done_cnt, done_cyc, last_tx_cyc + 1);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        busy_left = 0;
        busy_viol = 0;
        done_cnt = 0;
        done_cyc = 0;
        done_to = 1'b0;
        done_rc = 7'd0;
        last_tx_cyc = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_opcode = 8'd0;
        cmd_args = 80'd0;
        txBusy = 1'b0;
        rxReady = 1'b0;
        rxData = 8'd0;
        test_reset();
        test_version();
        test_args();
        test_long_resp();
        test_timeout();
        test_unknown();
        test_discards();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
